// File: rtl/cache_dm_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with one-word lines.
// One CPU request in flight; refill/evict over a valid/ready memory channel.
//
// state       | meaning
// IDLE        | waiting for a CPU request, cpu_req_ready high
// COMPARE     | tag lookup; hit completes, miss picks eviction or refill
// WRITEBACK   | dirty victim line offered to memory until accepted
// REFILL_REQ  | refill read request offered to memory until accepted
// REFILL_WAIT | waiting for refill data, then re-lookup in COMPARE
module cache_dm_wb_ctrl #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int INDEX_W  = 3,
   parameter int OFFSET_W = 2,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic              cpu_req_we,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   input  logic [DATA_W-1:0] cpu_req_wdata,
   output logic              cpu_resp_valid,
   output logic [DATA_W-1:0] cpu_resp_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL_REQ, REFILL_WAIT} state_t;

   state_t state, state_nxt;

   logic               req_we;
   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_idx;
   logic [DATA_W-1:0]  req_wdata;
   logic               refilled;

   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [DATA_W-1:0]  data_mem [LINES];
   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   dirty_q;

   logic hit;
   assign hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Memory-side outputs are decoded from state so reset clears them at once.
   always_comb begin
      state_nxt     = state;
      cpu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      case (state)
         IDLE: begin
            cpu_req_ready = 1'b1;
            if (cpu_req_valid) state_nxt = COMPARE;
         end
         COMPARE: begin
            if (hit)                                   state_nxt = IDLE;
            else if (valid_q[req_idx] && dirty_q[req_idx]) state_nxt = WRITEBACK;
            else                                       state_nxt = REFILL_REQ;
         end
         WRITEBACK: begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = {tag_mem[req_idx], req_idx, {OFFSET_W{1'b0}}};
            mem_req_wdata = data_mem[req_idx];
            if (mem_req_ready) state_nxt = REFILL_REQ;
         end
         REFILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {req_tag, req_idx, {OFFSET_W{1'b0}}};
            if (mem_req_ready) state_nxt = REFILL_WAIT;
         end
         REFILL_WAIT: begin
            if (mem_resp_valid) state_nxt = COMPARE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_we         <= 1'b0;
         req_tag        <= '0;
         req_idx        <= '0;
         req_wdata      <= '0;
         refilled       <= 1'b0;
         valid_q        <= '0;
         dirty_q        <= '0;
         cpu_resp_valid <= 1'b0;
         cpu_resp_rdata <= '0;
         hit_cnt        <= '0;
         miss_cnt       <= '0;
         for (int i = 0; i < LINES; i++) begin
            tag_mem[i]  <= '0;
            data_mem[i] <= '0;
         end
      end else begin
         cpu_resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req_valid) begin
                  req_we    <= cpu_req_we;
                  req_tag   <= cpu_req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
                  req_idx   <= cpu_req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
                  req_wdata <= cpu_req_wdata;
                  refilled  <= 1'b0;
               end
            end
            COMPARE: begin
               // The post-refill re-lookup is not a new access, so it is not counted.
               if (!refilled) begin
                  if (hit) begin
                     if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                  end else if (miss_cnt != '1) begin
                     miss_cnt <= miss_cnt + CNT_W'(1);
                  end
               end
               if (hit) begin
                  cpu_resp_valid <= 1'b1;
                  if (req_we) begin
                     data_mem[req_idx] <= req_wdata;
                     dirty_q[req_idx]  <= 1'b1;
                     cpu_resp_rdata    <= req_wdata;
                  end else begin
                     cpu_resp_rdata    <= data_mem[req_idx];
                  end
               end
            end
            WRITEBACK: begin
               if (mem_req_ready) dirty_q[req_idx] <= 1'b0;
            end
            REFILL_WAIT: begin
               if (mem_resp_valid) begin
                  data_mem[req_idx] <= mem_resp_rdata;
                  tag_mem[req_idx]  <= req_tag;
                  valid_q[req_idx]  <= 1'b1;
                  dirty_q[req_idx]  <= 1'b0;
                  refilled          <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_dm_wb_ctrl.sv
// Self-checking bench for cache_dm_wb_ctrl: directed scenarios plus random traffic
// checked against an array-based cache model and a responsive memory model.
module tb_cache_dm_wb_ctrl;

   localparam int CW  = 5;
   localparam int MAX = (1 << CW) - 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
   logic [31:0] cpu_req_addr, cpu_req_wdata;
   logic        cpu_resp_valid;
   logic [31:0] cpu_resp_rdata;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;
   logic [CW-1:0] hit_cnt, miss_cnt;

   cache_dm_wb_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   // Backing memory; unwritten words read as a hash of their address.
   logic [31:0] mem_model [logic [31:0]];

   // Reference cache: one word per line, 8 lines.
   bit          m_valid [8];
   bit          m_dirty [8];
   logic [26:0] m_tag   [8];
   logic [31:0] m_data  [8];
   int          m_hits, m_misses;

   typedef struct {
      bit          hit;
      bit          wb;
      logic [31:0] wb_addr, wb_data, rd_addr, rdata;
   } pred_t;

   typedef struct {
      logic [31:0] rdata, wr_addr, wr_data, rd_addr;
      int          lat, n_wr, n_rd;
      bit          wb_stable, ready_low, timeout;
   } res_t;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   function automatic int sat(input int v);
      return (v > MAX) ? MAX : v;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0;
      end
      m_hits = 0; m_misses = 0;
   endfunction

   function automatic pred_t model_access(input bit we, input logic [31:0] addr,
                                          input logic [31:0] wdata);
      pred_t p;
      int idx = int'(addr / 4) % 8;
      logic [26:0] tag = 27'(addr / 32);
      p.hit = m_valid[idx] && (m_tag[idx] == tag);
      p.wb = 0; p.wb_addr = '0; p.wb_data = '0; p.rd_addr = '0;
      if (p.hit) m_hits++;
      else begin
         m_misses++;
         if (m_valid[idx] && m_dirty[idx]) begin
            p.wb      = 1;
            p.wb_addr = 32'(m_tag[idx]) * 32 + 32'(idx) * 4;
            p.wb_data = m_data[idx];
         end
         p.rd_addr    = addr - (addr % 4);
         m_data[idx]  = mem_read(p.rd_addr);
         m_tag[idx]   = tag;
         m_valid[idx] = 1;
         m_dirty[idx] = 0;
      end
      if (we) begin
         m_data[idx]  = wdata;
         m_dirty[idx] = 1;
      end
      p.rdata = m_data[idx];
      return p;
   endfunction

   // Expected accept-to-response latency for the bench's memory timing.
   function automatic int exp_lat(input pred_t p, input int rdy_d, input int resp_d);
      if (p.hit) return 2;
      return 5 + rdy_d + resp_d + (p.wb ? 1 + rdy_d : 0);
   endfunction

   // Issues one request (entered and left just after a falling edge) and
   // plays the memory side until the response pulse.
   task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int rdy_d, input int resp_d, input bit hold,
                         input logic [31:0] hold_addr, output res_t r);
      int k = 0, guard = 0, wait_cnt = 0, resp_cnt = 0;
      bit pend = 0, done = 0, held = 0;
      logic [31:0] h_a = '0, h_d = '0, pend_a = '0;
      r.rdata = '0; r.wr_addr = '0; r.wr_data = '0; r.rd_addr = '0;
      r.lat = 0; r.n_wr = 0; r.n_rd = 0;
      r.wb_stable = 1; r.ready_low = 1; r.timeout = 0;
      cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
      while (!cpu_req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!cpu_req_ready) begin
         r.timeout = 1;
         cpu_req_valid = 0;
         return;
      end
      @(negedge clk);
      if (hold) begin
         cpu_req_we = 0; cpu_req_addr = hold_addr; cpu_req_wdata = '0;
      end else begin
         cpu_req_valid = 0;
      end
      k = 1;
      while (!done && k < 300) begin
         if (cpu_resp_valid) begin
            done = 1; r.rdata = cpu_resp_rdata; r.lat = k;
         end else begin
            if (cpu_req_ready) r.ready_low = 0;
            mem_req_ready = 0; mem_resp_valid = 0;
            if (pend) begin
               if (resp_cnt == 0) begin
                  mem_resp_valid = 1; mem_resp_rdata = mem_read(pend_a); pend = 0;
               end else resp_cnt--;
            end
            if (mem_req_valid) begin
               if (mem_req_we) begin
                  if (!held) begin
                     held = 1; h_a = mem_req_addr; h_d = mem_req_wdata;
                  end else if (mem_req_addr !== h_a || mem_req_wdata !== h_d) r.wb_stable = 0;
               end
               if (wait_cnt >= rdy_d) begin
                  mem_req_ready = 1; wait_cnt = 0; held = 0;
                  if (mem_req_we) begin
                     r.n_wr++; r.wr_addr = mem_req_addr; r.wr_data = mem_req_wdata;
                     mem_model[mem_req_addr] = mem_req_wdata;
                  end else begin
                     r.n_rd++; r.rd_addr = mem_req_addr;
                     pend = 1; resp_cnt = resp_d; pend_a = mem_req_addr;
                  end
               end else wait_cnt++;
            end
            @(negedge clk);
            k++;
         end
      end
      mem_req_ready = 0; mem_resp_valid = 0;
      if (!done) r.timeout = 1;
   endtask

   task automatic test_reset();
      reset = 1;
      cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
      repeat (3) @(negedge clk);
      reset = 0;
      model_reset();
      @(negedge clk);
      total++; if (cpu_req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cpu_req_ready); else passed++;
      total++; if (cpu_resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", cpu_resp_valid); else passed++;
      total++; if (cpu_resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata: got %h want 0", cpu_resp_rdata); else passed++;
      total++; if ({mem_req_valid, mem_req_we} !== 2'b00) $display("FAIL reset_mem_valid_we: got %b want 00", {mem_req_valid, mem_req_we}); else passed++;
      total++; if ({mem_req_addr, mem_req_wdata} !== 64'h0) $display("FAIL reset_mem_addr_data: got %h want 0", {mem_req_addr, mem_req_wdata}); else passed++;
      total++; if ({hit_cnt, miss_cnt} !== '0) $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); else passed++;
   endtask

   task automatic test_first_miss();
      res_t r; pred_t p;
      mem_model[32'h40] = 32'hDEAD_BEEF;
      p = model_access(0, 32'h40, '0);
      do_req(0, 32'h40, '0, 0, 0, 0, '0, r);
      total++; if (r.timeout) $display("FAIL first_miss_timeout: got timeout want response"); else passed++;
      total++; if (r.rdata !== 32'hDEAD_BEEF) $display("FAIL first_miss_rdata: got %h want deadbeef", r.rdata); else passed++;
      total++; if (r.n_rd != 1 || r.n_wr != 0 || r.rd_addr !== 32'h40) $display("FAIL first_miss_mem: got rd=%0d wr=%0d addr=%h want 1/0/00000040", r.n_rd, r.n_wr, r.rd_addr); else passed++;
      total++; if (r.lat != exp_lat(p, 0, 0)) $display("FAIL first_miss_latency: got %0d want %0d", r.lat, exp_lat(p, 0, 0)); else passed++;
      total++; if (miss_cnt !== CW'(1) || hit_cnt !== CW'(0)) $display("FAIL first_miss_counters: got hit=%0d miss=%0d want 0/1", hit_cnt, miss_cnt); else passed++;
   endtask

   task automatic test_hit_reread();
      res_t r; pred_t p;
      p = model_access(0, 32'h40, '0);
      do_req(0, 32'h40, '0, 0, 0, 0, '0, r);
      total++; if (r.lat != 2) $display("FAIL hit_latency: got %0d want 2", r.lat); else passed++;
      total++; if (r.rdata !== 32'hDEAD_BEEF) $display("FAIL hit_rdata: got %h want deadbeef", r.rdata); else passed++;
      total++; if (r.n_rd + r.n_wr != 0) $display("FAIL hit_no_mem: got %0d transfers want 0", r.n_rd + r.n_wr); else passed++;
      total++; if (hit_cnt !== CW'(1)) $display("FAIL hit_count: got %0d want 1", hit_cnt); else passed++;
   endtask

   task automatic test_write_evict();
      res_t r; pred_t p;
      p = model_access(1, 32'h40, 32'h1234_5678);
      do_req(1, 32'h40, 32'h1234_5678, 0, 0, 0, '0, r);
      total++; if (r.lat != 2 || r.rdata !== 32'h1234_5678) $display("FAIL write_hit: got lat=%0d data=%h want 2/12345678", r.lat, r.rdata); else passed++;
      total++; if (r.n_rd + r.n_wr != 0) $display("FAIL write_hit_no_mem: got %0d transfers want 0", r.n_rd + r.n_wr); else passed++;
      p = model_access(0, 32'h60, '0);
      do_req(0, 32'h60, '0, 5, 1, 0, '0, r);
      total++; if (r.n_wr != 1 || r.wr_addr !== 32'h40 || r.wr_data !== 32'h1234_5678) $display("FAIL evict_write: got n=%0d addr=%h data=%h want 1/00000040/12345678", r.n_wr, r.wr_addr, r.wr_data); else passed++;
      total++; if (!r.wb_stable) $display("FAIL evict_stall_stable: got unstable want stable"); else passed++;
      total++; if (r.n_rd != 1 || r.rd_addr !== 32'h60) $display("FAIL evict_refill: got n=%0d addr=%h want 1/00000060", r.n_rd, r.rd_addr); else passed++;
      total++; if (r.rdata !== p.rdata || r.lat != exp_lat(p, 5, 1)) $display("FAIL evict_resp: got %h lat=%0d want %h lat=%0d", r.rdata, r.lat, p.rdata, exp_lat(p, 5, 1)); else passed++;
      total++; if (miss_cnt !== CW'(2)) $display("FAIL evict_miss_count: got %0d want 2", miss_cnt); else passed++;
   endtask

   task automatic test_reset_mid();
      res_t r; pred_t p;
      int g = 0;
      cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 32'h84; cpu_req_wdata = '0;
      @(negedge clk);
      cpu_req_valid = 0;
      while (!(mem_req_valid && !mem_req_we) && g < 20) begin
         @(negedge clk);
         g++;
      end
      total++; if (!mem_req_valid) $display("FAIL reset_mid_refill_req: got no request want refill read"); else passed++;
      mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      @(negedge clk);
      total++; if (miss_cnt !== CW'(3)) $display("FAIL reset_mid_pre_count: got %0d want 3", miss_cnt); else passed++;
      reset = 1;
      #1;
      total++; if ({mem_req_valid, cpu_resp_valid} !== 2'b00) $display("FAIL reset_mid_valids: got %b want 00", {mem_req_valid, cpu_resp_valid}); else passed++;
      total++; if ({hit_cnt, miss_cnt} !== '0) $display("FAIL reset_mid_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); else passed++;
      @(negedge clk);
      reset = 0;
      model_reset();
      @(negedge clk);
      p = model_access(0, 32'h40, '0);
      do_req(0, 32'h40, '0, 1, 0, 0, '0, r);
      total++; if (r.n_rd != 1 || r.rdata !== 32'h1234_5678) $display("FAIL reset_mid_remiss: got rd=%0d data=%h want 1/12345678", r.n_rd, r.rdata); else passed++;
      total++; if (miss_cnt !== CW'(1) || hit_cnt !== CW'(0)) $display("FAIL reset_mid_after_counts: got hit=%0d miss=%0d want 0/1", hit_cnt, miss_cnt); else passed++;
   endtask

   task automatic test_back_to_back();
      res_t r; pred_t pa, pb;
      pa = model_access(0, 32'hA4, '0);
      do_req(0, 32'hA4, '0, 1, 2, 1, 32'hC8, r);
      total++; if (!r.ready_low) $display("FAIL b2b_ready_low: got ready during miss want 0"); else passed++;
      total++; if (r.rdata !== pa.rdata || r.lat != exp_lat(pa, 1, 2)) $display("FAIL b2b_first: got %h lat=%0d want %h lat=%0d", r.rdata, r.lat, pa.rdata, exp_lat(pa, 1, 2)); else passed++;
      pb = model_access(0, 32'hC8, '0);
      do_req(0, 32'hC8, '0, 0, 0, 0, '0, r);
      total++; if (r.n_rd != 1 || r.rd_addr !== 32'hC8 || r.rdata !== pb.rdata) $display("FAIL b2b_second: got rd=%0d addr=%h data=%h want 1/000000c8/%h", r.n_rd, r.rd_addr, r.rdata, pb.rdata); else passed++;
      mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      mem_resp_valid = 0;
      total++; if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) $display("FAIL late_resp_idle: got ready=%b resp=%b mreq=%b want 1/0/0", cpu_req_ready, cpu_resp_valid, mem_req_valid); else passed++;
      pa = model_access(0, 32'hA4, '0);
      do_req(0, 32'hA4, '0, 0, 0, 0, '0, r);
      total++; if (r.rdata !== pa.rdata || r.n_rd + r.n_wr != 0) $display("FAIL late_resp_no_effect: got %h xfers=%0d want %h/0", r.rdata, r.n_rd + r.n_wr, pa.rdata); else passed++;
      total++; if (hit_cnt !== CW'(sat(m_hits))) $display("FAIL b2b_hit_count: got %0d want %0d", hit_cnt, sat(m_hits)); else passed++;
   endtask

   task automatic test_random();
      res_t r; pred_t p;
      int nbad = 0;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a = 32'($urandom_range(0, 3)) * 32 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         bit we = 1'($urandom_range(0, 1));
         logic [31:0] wd = $urandom;
         int rd_d = $urandom_range(0, 3), rs_d = $urandom_range(0, 3);
         p = model_access(we, a, wd);
         do_req(we, a, wd, rd_d, rs_d, 0, '0, r);
         total++; if (r.timeout || r.rdata !== p.rdata) begin nbad++; $display("FAIL rand_rdata[%0d]: got %h to=%0b want %h", i, r.rdata, r.timeout, p.rdata); end else passed++;
         total++; if (r.lat != exp_lat(p, rd_d, rs_d)) $display("FAIL rand_latency[%0d]: got %0d want %0d", i, r.lat, exp_lat(p, rd_d, rs_d)); else passed++;
         total++; if (r.n_wr != int'(p.wb) || (p.wb && (r.wr_addr !== p.wb_addr || r.wr_data !== p.wb_data)) || !r.wb_stable)
            $display("FAIL rand_writeback[%0d]: got n=%0d %h/%h want n=%0d %h/%h", i, r.n_wr, r.wr_addr, r.wr_data, p.wb, p.wb_addr, p.wb_data);
         else passed++;
         total++; if (r.n_rd != (p.hit ? 0 : 1) || (!p.hit && r.rd_addr !== p.rd_addr)) $display("FAIL rand_refill[%0d]: got n=%0d %h want n=%0d %h", i, r.n_rd, r.rd_addr, !p.hit, p.rd_addr); else passed++;
         total++; if (hit_cnt !== CW'(sat(m_hits)) || miss_cnt !== CW'(sat(m_misses))) $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d", i, hit_cnt, miss_cnt, sat(m_hits), sat(m_misses)); else passed++;
         if (nbad > 5) break;
      end
   endtask

   task automatic test_saturation();
      res_t r; pred_t p;
      int g = 0;
      while (m_hits < MAX + 3 && g < 100) begin
         p = model_access(0, 32'h10, '0);
         do_req(0, 32'h10, '0, 0, 0, 0, '0, r);
         g++;
      end
      total++; if (hit_cnt !== CW'(MAX)) $display("FAIL hit_saturation: got %0d want %0d", hit_cnt, MAX); else passed++;
      total++; if (miss_cnt !== CW'(sat(m_misses))) $display("FAIL miss_saturation: got %0d want %0d", miss_cnt, sat(m_misses)); else passed++;
   endtask

   initial begin
      test_reset();
      test_first_miss();
      test_hit_reread();
      test_write_evict();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cache_dm_wb_ctrl.md
Name: cache_dm_wb_ctrl

Overview:
- Parametrised direct-mapped, write-back, write-allocate cache.
- Holds its own tag, data, valid and dirty arrays.
- Serves one CPU request at a time over a valid/ready request channel and a one-cycle response pulse.
- Fetches and evicts one-word lines over a valid/ready memory channel; keeps saturating hit/miss counters for performance debug.

Parameters:
- ADDR_W, 32, CPU/memory byte-address width.
- DATA_W, 32, word and line width (one word per line).
- INDEX_W, 3, line index bits; 2**INDEX_W lines.
- OFFSET_W, 2, byte-offset bits; ignored for lookup, forced to 0 on memory addresses.
- CNT_W, 16, hit/miss counter width.
- Derived TAG_W = ADDR_W-INDEX_W-OFFSET_W (27 at defaults).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  controller can accept a request (high only in IDLE).
- cpu_req_we  in  1  1=write, 0=read.
- cpu_req_addr  in  ADDR_W  byte address.
- cpu_req_wdata  in  DATA_W  write data.
- cpu_resp_valid  out  1  one-cycle completion pulse (reads and writes).
- cpu_resp_rdata  out  DATA_W  read data, valid with cpu_resp_valid.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  1=writeback, 0=refill read.
- mem_req_addr  out  ADDR_W  line address, low OFFSET_W bits zero.
- mem_req_wdata  out  DATA_W  writeback data.
- mem_resp_valid  in  1  refill data present.
- mem_resp_rdata  in  DATA_W  refill data.
- hit_cnt  out  CNT_W  first-lookup hits.
- miss_cnt  out  CNT_W  first-lookup misses.

Behaviour:
- Address split: tag=[ADDR_W-1:INDEX_W+OFFSET_W], index=[INDEX_W+OFFSET_W-1:OFFSET_W].
- Reset (async, any state):
  - state=IDLE; all valid, dirty, tag and data entries =0; counters =0.
  - cpu_resp_valid=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, cpu_resp_rdata=0.
  - cpu_req_ready=1 once reset is deasserted.
- States: IDLE, COMPARE, WRITEBACK, REFILL_REQ, REFILL_WAIT.
- IDLE:
  - cpu_req_ready=1.
  - Handshake (valid&ready) latches we/addr/wdata, clears the refilled flag, moves to COMPARE.
- COMPARE (cpu_req_ready=0): hit = valid[idx] & tag match.
  - Hit, read: cpu_resp_rdata=data[idx], cpu_resp_valid=1 next cycle; go to IDLE. A request accepted in cycle N completes in cycle N+2.
  - Hit, write: data[idx]=wdata, dirty[idx]=1, resp pulse next cycle with cpu_resp_rdata=wdata; go to IDLE.
  - Miss with valid&dirty: go to WRITEBACK.
  - Miss otherwise: go to REFILL_REQ.
  - Counting: hit_cnt or miss_cnt +1 only when refilled=0. Both saturate at all-ones, no wrap.
- WRITEBACK:
  - Drive mem_req_valid=1, we=1, addr={old tag,idx,0}, wdata=data[idx].
  - All held stable until mem_req_ready; no write response expected.
  - On handshake: dirty[idx]=0, go to REFILL_REQ.
- REFILL_REQ:
  - Drive mem_req_valid=1, we=0, addr={req tag,idx,0}, held until mem_req_ready.
  - Then go to REFILL_WAIT with mem_req_valid=0.
- REFILL_WAIT:
  - On mem_resp_valid: data[idx]=mem_resp_rdata, tag[idx]=req tag, valid=1, dirty=0, refilled=1; go to COMPARE.
  - The re-lookup hits and completes as above; a write miss therefore merges on this pass.
- Ignored inputs:
  - cpu_req_valid outside IDLE (not accepted; the CPU holds it).
  - mem_resp_valid outside REFILL_WAIT.
- Latency:
  - Clean miss: 2 + mem handshake + response wait + 2 cycles.
  - mem_req_valid never asserts on a hit.

Test Plan:
- After reset, read 0x40 → cpu_req_ready=1 from the first post-reset edge; mem read addr 0x40; memory answers 0xDEADBEEF → cpu_resp_rdata=0xDEADBEEF; miss_cnt=1, hit_cnt=0.
- Re-read 0x40 → cpu_resp_valid exactly 2 cycles after accept, data 0xDEADBEEF, no mem_req_valid, hit_cnt=1.
- Write 0x40 data 0x12345678 (hit), then read 0x60 (same index 0, tag 3) → mem write addr 0x40 data 0x12345678, then mem read addr 0x60; miss_cnt=2.
- Hold mem_req_ready=0 for 5 cycles during WRITEBACK → mem_req_valid/addr/wdata constant throughout; exactly one write transfer.
- Assert reset during REFILL_WAIT → mem_req_valid, cpu_resp_valid and counters are 0 immediately (before the next edge); afterwards, read 0x40 misses.
- Hold cpu_req_valid high during a miss with a different address → second request accepted only after the first response; late mem_resp_valid in IDLE has no effect.
